// File: rtl/forth_boot_ctrl.sv
// Boot/reload sequencer for the forth core: receives a framed byte image
// (A5, len16, data words lo/hi, xor checksum), writes it to imem, then releases the core.
module forth_boot_ctrl #(
  parameter int iaddr_width = 10,
  parameter int instr_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   start,
  output logic [iaddr_width-1:0] imem_addr,
  output logic [instr_width-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   core_reset,
  output logic                   done,
  output logic                   err
);

  // state  | meaning
  // SYNC   | hunting for the 0xA5 sync byte
  // LEN_LO | expecting low length byte
  // LEN_HI | expecting high length byte, length validated here
  // DAT_LO | expecting low byte of the next word
  // DAT_HI | expecting high byte; word written on the following cycle
  // CSUM   | expecting the xor checksum byte
  // RUN    | image good, core released
  // ERR    | bad length or checksum, core held in reset
  typedef enum logic [2:0] {
    SYNC, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CSUM, RUN, ERR
  } state_t;

  localparam int cnt_w = iaddr_width + 1;
  localparam logic [16:0] max_len = 17'(1 << iaddr_width);

  state_t                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [7:0]             lo_q, lo_d;
  logic [7:0]             csum_q, csum_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic [iaddr_width-1:0] addr_q, addr_d;
  logic [instr_width-1:0] wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   core_reset_q, core_reset_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic        accept;
  logic [15:0] len_full;
  logic [16:0] cnt_next_ext;

  assign rx_ready     = (state_q != RUN) && (state_q != ERR);
  assign accept       = rx_valid && rx_ready;
  assign len_full     = {rx_data, len_q[7:0]};
  assign cnt_next_ext = 17'(cnt_q) + 17'd1;

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign imem_we    = we_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      len_q        <= '0;
      lo_q         <= '0;
      csum_q       <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      lo_q         <= lo_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    case (state_q)
      SYNC: begin
        if (accept && rx_data == 8'hA5) begin
          state_d = LEN_LO;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0 || {1'b0, len_full} > max_len) begin
            state_d = ERR;
          end else begin
            state_d = DAT_LO;
          end
        end
      end
      DAT_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          csum_d  = csum_q ^ rx_data;
          we_d    = 1'b1;
          addr_d  = cnt_q[iaddr_width-1:0];
          wdata_d = instr_width'({rx_data, lo_q});
          cnt_d   = cnt_q + cnt_w'(1);
          // counter is one bit wider than the address so len = 2**iaddr_width terminates cleanly
          if (cnt_next_ext == {1'b0, len_q}) begin
            state_d = CSUM;
          end else begin
            state_d = DAT_LO;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? RUN : ERR;
        end
      end
      RUN: begin
        if (start) state_d = SYNC;
      end
      ERR: begin
        if (start) state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase

    core_reset_d = (state_d != RUN);
    done_d       = (state_d == RUN);
    err_d        = (state_d == ERR);
  end

endmodule

// File: tb/tb_forth_boot_ctrl.sv
// Directed self-checking bench for forth_boot_ctrl: framed loads, bad checksum,
// length limits, throttled input, start handling and async reset mid-load.
module tb_forth_boot_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        imem_we;
  logic        core_reset;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // write log captured from the imem port
  logic [15:0] wlog [0:1023];
  int          wr_cnt    = 0;
  int          we_double = 0;
  logic [9:0]  last_addr = '0;
  logic        we_prev   = 1'b0;

  forth_boot_ctrl #(.iaddr_width(10), .instr_width(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      wlog[imem_addr] = imem_wdata;
      last_addr = imem_addr;
      if (we_prev === 1'b1) we_double++;
    end
    we_prev = imem_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (throttle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_cnt    = 0;
    we_double = 0;
    wlog[0]   = 16'h0000;
    wlog[1]   = 16'h0000;
  endtask

  task automatic send_test1(input logic [7:0] csum_b, input bit throttle);
    send_byte(8'hA5, throttle);
    send_byte(8'h02, throttle);
    send_byte(8'h00, throttle);
    send_byte(8'h34, throttle);
    send_byte(8'h12, throttle);
    send_byte(8'h78, throttle);
    send_byte(8'h56, throttle);
    send_byte(csum_b, throttle);
  endtask

  function automatic logic [15:0] big_word(input int i);
    logic [9:0] a;
    a = 10'(i);
    return {a[9:2] ^ 8'h3C, a[7:0]};
  endfunction

  task automatic test_reset();
    n_checks++;
    if (core_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: core_reset=%b done=%b err=%b want 1 0 0", core_reset, done, err);
    end
    n_checks++;
    if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_imem: we=%b addr=%h data=%h want 0 0 0", imem_we, imem_addr, imem_wdata);
    end
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rx_ready: got %b want 1", rx_ready);
    end
  endtask

  task automatic test_basic();
    clear_log();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    n_checks++;
    if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_word0_latency: we=%b addr=%h data=%h want 1 000 1234", imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    n_checks++;
    if (imem_we !== 1'b1 || imem_addr !== 10'd1 || imem_wdata !== 16'h5678) begin
      n_fail++;
      $display("FAIL basic_word1_latency: we=%b addr=%h data=%h want 1 001 5678", imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'h08, 1'b0);
    n_checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || err !== 1'b0 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_run: done=%b core_reset=%b err=%b rx_ready=%b want 1 0 0 0", done, core_reset, err, rx_ready);
    end
    n_checks++;
    if (wr_cnt != 2 || we_double != 0 || wlog[0] !== 16'h1234 || wlog[1] !== 16'h5678) begin
      n_fail++;
      $display("FAIL basic_writes: count=%0d doubles=%0d w0=%h w1=%h want 2 0 1234 5678", wr_cnt, we_double, wlog[0], wlog[1]);
    end
  endtask

  task automatic test_start_in_run();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL run_hold: done=%b core_reset=%b want 1 0", done, core_reset);
    end
    pulse_start();
    n_checks++;
    if (core_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start: core_reset=%b done=%b rx_ready=%b want 1 0 1", core_reset, done, rx_ready);
    end
  endtask

  task automatic test_bad_csum();
    clear_log();
    send_test1(8'h2F, 1'b0);
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL badcsum_err: err=%b done=%b core_reset=%b rx_ready=%b want 1 0 1 0", err, done, core_reset, rx_ready);
    end
    n_checks++;
    if (wr_cnt != 2 || wlog[0] !== 16'h1234 || wlog[1] !== 16'h5678) begin
      n_fail++;
      $display("FAIL badcsum_writes: count=%0d w0=%h w1=%h want 2 1234 5678", wr_cnt, wlog[0], wlog[1]);
    end
    send_byte(8'hA5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL badcsum_hold: err=%b rx_ready=%b want 1 0", err, rx_ready);
    end
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || rx_ready !== 1'b1 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL badcsum_start: err=%b rx_ready=%b core_reset=%b want 0 1 1", err, rx_ready, core_reset);
    end
  endtask

  task automatic test_garbage();
    clear_log();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h13, 1'b0);
    send_test1(8'h08, 1'b0);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || wr_cnt != 2 || wlog[0] !== 16'h1234 || wlog[1] !== 16'h5678) begin
      n_fail++;
      $display("FAIL garbage_load: done=%b err=%b count=%0d w0=%h w1=%h want 1 0 2 1234 5678", done, err, wr_cnt, wlog[0], wlog[1]);
    end
    pulse_start();
  endtask

  task automatic test_len_limits();
    clear_log();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || wr_cnt != 0) begin
      n_fail++;
      $display("FAIL len_zero: err=%b writes=%0d want 1 0", err, wr_cnt);
    end
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    n_checks++;
    if (err !== 1'b1 || wr_cnt != 0) begin
      n_fail++;
      $display("FAIL len_1025: err=%b writes=%0d want 1 0", err, wr_cnt);
    end
    pulse_start();
  endtask

  task automatic test_len_max();
    logic [7:0]  cs;
    logic [15:0] w;
    clear_log();
    cs = 8'h00;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      w  = big_word(i);
      cs = cs ^ w[7:0] ^ w[15:8];
      send_byte(w[7:0], 1'b0);
      send_byte(w[15:8], 1'b0);
    end
    n_checks++;
    if (done !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lenmax_wait_csum: done=%b rx_ready=%b want 0 1", done, rx_ready);
    end
    send_byte(cs, 1'b0);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL lenmax_done: done=%b err=%b core_reset=%b want 1 0 0", done, err, core_reset);
    end
    n_checks++;
    if (wr_cnt != 1024 || last_addr !== 10'd1023 || we_double != 0) begin
      n_fail++;
      $display("FAIL lenmax_count: writes=%0d last=%0d doubles=%0d want 1024 1023 0", wr_cnt, last_addr, we_double);
    end
    n_checks++;
    if (wlog[0] !== big_word(0) || wlog[1023] !== big_word(1023) || wlog[517] !== big_word(517)) begin
      n_fail++;
      $display("FAIL lenmax_data: w0=%h w517=%h w1023=%h want %h %h %h", wlog[0], wlog[517], wlog[1023],
               big_word(0), big_word(517), big_word(1023));
    end
    pulse_start();
  endtask

  task automatic test_throttled();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b0);
    // idle cycle carries a start pulse, which must not abort the load
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (core_reset !== 1'b1 || rx_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_start_ignored: core_reset=%b rx_ready=%b err=%b want 1 1 0", core_reset, rx_ready, err);
    end
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h08, 1'b0);
    n_checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || wr_cnt != 2 || we_double != 0 ||
        wlog[0] !== 16'h1234 || wlog[1] !== 16'h5678) begin
      n_fail++;
      $display("FAIL throttle_load: done=%b core_reset=%b writes=%0d w0=%h w1=%h want 1 0 2 1234 5678",
               done, core_reset, wr_cnt, wlog[0], wlog[1]);
    end
    pulse_start();
  endtask

  task automatic test_reset_midload();
    clear_log();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (core_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rx_ready !== 1'b1 ||
        imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL midload_reset: core_reset=%b done=%b err=%b rx_ready=%b we=%b addr=%h data=%h want 1 0 0 1 0 0 0",
               core_reset, done, err, rx_ready, imem_we, imem_addr, imem_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_test1(8'h08, 1'b0);
    n_checks++;
    if (done !== 1'b1 || wr_cnt != 2 || wlog[0] !== 16'h1234 || wlog[1] !== 16'h5678) begin
      n_fail++;
      $display("FAIL midload_reload: done=%b writes=%0d w0=%h w1=%h want 1 2 1234 5678", done, wr_cnt, wlog[0], wlog[1]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_start_in_run();
    test_bad_csum();
    test_garbage();
    test_len_limits();
    test_len_max();
    test_throttled();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
